// File: rtl/memblock_tbus_arb_pkg.sv
// -----------------------------------------------------------------------------
// memblock_tbus_arb_pkg
//   Shared memblock definitions for the tbus arbiter: bus width, operation
//   type constants, FSM state encoding and requester (owner) encoding.
//   No ports; imported by the interface, the arbiter top and the picker.
// -----------------------------------------------------------------------------
package memblock_tbus_arb_pkg;

  localparam int TBUS_W = 64;

  // Operation type carried on *_operation_type
  localparam logic [1:0] TBUS_READ  = 2'd0;
  localparam logic [1:0] TBUS_WRITE = 2'd1;

  // Arbiter FSM:
  //   IDLE        - free, grants combinationally to any valid requester
  //   LOCKED      - request presented downstream, not yet accepted
  //   OUTSTANDING - accepted downstream, waiting for operation_done
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOCKED      = 2'd1,
    OUTSTANDING = 2'd2
  } arb_state_t;

  // Requester identity; bit position in the picker's one-hot vectors
  // matches this encoding (bit 0 = load unit, bit 1 = store queue).
  typedef enum logic {
    OWNER_LDU = 1'b0,
    OWNER_STU = 1'b1
  } owner_t;

  // Convert a one-hot grant vector into the owner encoding.
  function automatic owner_t grant_to_owner(input logic [1:0] grant);
    return grant[1] ? OWNER_STU : OWNER_LDU;
  endfunction

endpackage

// File: rtl/memblock_tbus_arb_if.sv
// -----------------------------------------------------------------------------
// memblock_tbus_arb_if
//   One tbus link: request handshake, request payload and response.
//   master : drives index_valid + payload, receives ready/read_data/done
//   slave  : receives index_valid + payload, drives ready/read_data/done
//   Signals:
//     index_valid / index_ready   request handshake
//     index, write_data, write_mask (64b), operation_type (2b) payload
//     read_data (64b), operation_done   response
// -----------------------------------------------------------------------------
interface memblock_tbus_arb_if;
  import memblock_tbus_arb_pkg::*;

  logic              index_valid;
  logic              index_ready;
  logic [TBUS_W-1:0] index;
  logic [TBUS_W-1:0] write_data;
  logic [TBUS_W-1:0] write_mask;
  logic [1:0]        operation_type;
  logic [TBUS_W-1:0] read_data;
  logic              operation_done;

  modport master (
    output index_valid,
    output index,
    output write_data,
    output write_mask,
    output operation_type,
    input  index_ready,
    input  read_data,
    input  operation_done
  );

  modport slave (
    input  index_valid,
    input  index,
    input  write_data,
    input  write_mask,
    input  operation_type,
    output index_ready,
    output read_data,
    output operation_done
  );

endinterface

// File: rtl/memblock_tbus_arb_rr_picker.sv
// -----------------------------------------------------------------------------
// tbus_rr_picker
//   Two-requester grant selection, purely combinational.
//   Ports:
//     req        in  [1:0] request vector (bit 0 = load, bit 1 = store)
//     last_grant in        requester that won the previous downstream fire
//     grant      out [1:0] one-hot grant (all zero when nothing requests)
//   RR_EN = 1 : on a tie the requester not granted last wins
//   RR_EN = 0 : on a tie the load unit always wins
// -----------------------------------------------------------------------------
module tbus_rr_picker
  import memblock_tbus_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // A single requester is granted directly; only a tie needs the policy.
    grant = req;
    if (req == 2'b11) begin
      if ((RR_EN != 0) && (last_grant == OWNER_LDU)) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end
  end

endmodule

// File: rtl/memblock_tbus_arb.sv
// -----------------------------------------------------------------------------
// memblock_tbus_arb
//   Arbitrates the load unit and the store-queue drain onto the single dcache
//   tbus port. At most one transaction is in flight. Grant and done routing
//   are combinational (zero added latency); ownership is held from grant until
//   the downstream done so payload cannot switch under backpressure.
//   Ports:
//     clock                  single clock, rising edge
//     reset_n                asynchronous active-low reset; while low every
//                            output is forced to zero
//     memblock2dcache_flush  redirect: kills a load owned request/transaction
//     ldu_tbus   (slave)     load-unit requester
//     stu_tbus   (slave)     store-queue drain requester
//     arb2dcache_tbus (master) downstream dcache port
//   Parameter RR_EN: 1 = round-robin on ties, 0 = load unit always wins ties.
// -----------------------------------------------------------------------------
module memblock_tbus_arb
  import memblock_tbus_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       memblock2dcache_flush,
  memblock_tbus_arb_if.slave         ldu_tbus,
  memblock_tbus_arb_if.slave         stu_tbus,
  memblock_tbus_arb_if.master        arb2dcache_tbus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t state_reg;
  owner_t     owner_reg;       // requester holding the bus (LOCKED/OUTSTANDING)
  owner_t     last_grant_reg;  // requester of the most recent downstream fire
  logic       drop_reg;        // load killed while outstanding: swallow its done

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [1:0] pick_grant;
  owner_t     sel_owner;       // requester whose payload is presented now
  logic       down_valid;      // request presented downstream (before reset gate)
  logic       present;         // downstream valid as seen on the port
  logic       fire;
  logic       load_kill;
  logic       done_in;

  tbus_rr_picker #(
    .RR_EN (RR_EN)
  ) u_picker (
    .req        ({stu_tbus.index_valid, ldu_tbus.index_valid}),
    .last_grant (last_grant_reg),
    .grant      (pick_grant)
  );

  // The flush only ever targets the load unit; a store owner is immune.
  assign load_kill = memblock2dcache_flush && (owner_reg == OWNER_LDU);

  always_comb begin
    sel_owner  = owner_reg;
    down_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        sel_owner  = grant_to_owner(pick_grant);
        down_valid = |pick_grant;
      end
      LOCKED: begin
        // Held request stays presented until accepted; a killed load is
        // withdrawn in the very cycle of the flush.
        down_valid = !load_kill;
      end
      default: begin
        down_valid = 1'b0;
      end
    endcase
  end

  assign present = reset_n && down_valid;
  assign fire    = present && arb2dcache_tbus.index_ready;

  // Done is only meaningful while a transaction is outstanding; anything
  // else (including a done left over from before a reset) is ignored.
  assign done_in = reset_n && (state_reg == OUTSTANDING) &&
                   arb2dcache_tbus.operation_done;

  // Downstream request: payload follows the presenting requester, and is
  // zero whenever nothing is presented.
  always_comb begin
    arb2dcache_tbus.index_valid    = present;
    arb2dcache_tbus.index          = '0;
    arb2dcache_tbus.write_data     = '0;
    arb2dcache_tbus.write_mask     = '0;
    arb2dcache_tbus.operation_type = '0;
    if (present) begin
      if (sel_owner == OWNER_LDU) begin
        arb2dcache_tbus.index          = ldu_tbus.index;
        arb2dcache_tbus.write_data     = ldu_tbus.write_data;
        arb2dcache_tbus.write_mask     = ldu_tbus.write_mask;
        arb2dcache_tbus.operation_type = ldu_tbus.operation_type;
      end else begin
        arb2dcache_tbus.index          = stu_tbus.index;
        arb2dcache_tbus.write_data     = stu_tbus.write_data;
        arb2dcache_tbus.write_mask     = stu_tbus.write_mask;
        arb2dcache_tbus.operation_type = stu_tbus.operation_type;
      end
    end
  end

  // Accept pulse goes only to the requester whose payload was taken.
  assign ldu_tbus.index_ready = fire && (sel_owner == OWNER_LDU);
  assign stu_tbus.index_ready = fire && (sel_owner == OWNER_STU);

  // Done routing. A flush coinciding with the load's done also kills it:
  // the redirect has already made that load's result useless.
  assign ldu_tbus.operation_done = done_in && (owner_reg == OWNER_LDU) &&
                                   !drop_reg && !memblock2dcache_flush;
  assign stu_tbus.operation_done = done_in && (owner_reg == OWNER_STU);

  // Read data is broadcast; the done pulse says who should take it.
  assign ldu_tbus.read_data = reset_n ? arb2dcache_tbus.read_data : '0;
  assign stu_tbus.read_data = reset_n ? arb2dcache_tbus.read_data : '0;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWNER_STU;
      last_grant_reg <= OWNER_STU;  // load wins the first tie after reset
      drop_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (down_valid) begin
            owner_reg <= sel_owner;
            if (fire) begin
              state_reg      <= OUTSTANDING;
              last_grant_reg <= sel_owner;
            end else begin
              state_reg <= LOCKED;
            end
          end
        end

        LOCKED: begin
          if (load_kill) begin
            state_reg <= IDLE;
          end else if (fire) begin
            state_reg      <= OUTSTANDING;
            last_grant_reg <= owner_reg;
          end
        end

        OUTSTANDING: begin
          // A new request arriving alongside done is granted from IDLE on
          // the following cycle, never in the completing cycle.
          if (arb2dcache_tbus.operation_done) begin
            state_reg <= IDLE;
            drop_reg  <= 1'b0;
          end else if (load_kill) begin
            drop_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memblock_tbus_arb.sv
// -----------------------------------------------------------------------------
// tb_memblock_tbus_arb
//   Drives two arbiters (RR_EN = 1 and RR_EN = 0) with identical stimulus and
//   compares every output, every cycle, against a transaction-level reference
//   model. Directed scenarios come first, then a long randomized run with
//   random flushes, stray dones and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_memblock_tbus_arb;
  import memblock_tbus_arb_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  // Shared stimulus
  logic        s_lv, s_sv, s_ready, s_done, s_flush;
  logic [63:0] s_lidx, s_lwd, s_lwm, s_sidx, s_swd, s_swm, s_rdata;
  logic [1:0]  s_lop, s_sop;

  // Observed outputs, index = instance (0: RR_EN=1, 1: RR_EN=0)
  logic [1:0]  a_valid, a_lrdy, a_srdy, a_ldone, a_sdone;
  logic [63:0] a_idx [2];
  logic [63:0] a_wd  [2];
  logic [63:0] a_wm  [2];
  logic [63:0] a_lrd [2];
  logic [63:0] a_srd [2];
  logic [1:0]  a_op  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    memblock_tbus_arb_if ldu_if ();
    memblock_tbus_arb_if stu_if ();
    memblock_tbus_arb_if dc_if  ();

    assign ldu_if.index_valid    = s_lv;
    assign ldu_if.index          = s_lidx;
    assign ldu_if.write_data     = s_lwd;
    assign ldu_if.write_mask     = s_lwm;
    assign ldu_if.operation_type = s_lop;
    assign stu_if.index_valid    = s_sv;
    assign stu_if.index          = s_sidx;
    assign stu_if.write_data     = s_swd;
    assign stu_if.write_mask     = s_swm;
    assign stu_if.operation_type = s_sop;
    assign dc_if.index_ready     = s_ready;
    assign dc_if.operation_done  = s_done;
    assign dc_if.read_data       = s_rdata;

    assign a_valid[gi] = dc_if.index_valid;
    assign a_idx[gi]   = dc_if.index;
    assign a_wd[gi]    = dc_if.write_data;
    assign a_wm[gi]    = dc_if.write_mask;
    assign a_op[gi]    = dc_if.operation_type;
    assign a_lrdy[gi]  = ldu_if.index_ready;
    assign a_srdy[gi]  = stu_if.index_ready;
    assign a_ldone[gi] = ldu_if.operation_done;
    assign a_sdone[gi] = stu_if.operation_done;
    assign a_lrd[gi]   = ldu_if.read_data;
    assign a_srd[gi]   = stu_if.read_data;

    memblock_tbus_arb #(
      .RR_EN (gi == 0 ? 1 : 0)
    ) u_dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .memblock2dcache_flush (s_flush),
      .ldu_tbus              (ldu_if),
      .stu_tbus              (stu_if),
      .arb2dcache_tbus       (dc_if)
    );
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one pending transaction record per arbiter.
  //   m_have : a transaction owns the bus
  //   m_acc  : the dcache has accepted it
  //   m_who  : owner (0 load, 1 store)
  //   m_sq   : the load's result was squashed by a redirect
  //   m_last : winner of the most recent accepted request
  // ---------------------------------------------------------------------------
  bit m_have [2];
  bit m_acc  [2];
  bit m_sq   [2];
  int m_who  [2];
  int m_last [2];

  // Snapshot of outputs at the last sample point, for directed checks
  logic [1:0]  sn_valid, sn_lrdy, sn_srdy, sn_ldone, sn_sdone;
  logic [63:0] sn_idx [2];
  logic [63:0] sn_lrd [2];

  // Expected accept pulses of instance 0, used to pace the random requesters
  bit e_lrdy0, e_srdy0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_have[k] = 1'b0;
      m_acc[k]  = 1'b0;
      m_sq[k]   = 1'b0;
      m_who[k]  = 1;
      m_last[k] = 1;
    end
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // model across the rising edge. Inputs are changed only between calls.
  task automatic step();
    bit nh [2];
    bit na [2];
    bit ns [2];
    int nw [2];
    int nl [2];
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      bit rr, dv, fire, done_eff, e_ld, e_sd;
      int who_now;
      logic [63:0] e_idx, e_wd, e_wm;
      logic [1:0]  e_op;
      string p;
      p  = $sformatf("i%0d.", k);
      rr = (k == 0);
      nh[k] = m_have[k]; na[k] = m_acc[k]; ns[k] = m_sq[k];
      nw[k] = m_who[k];  nl[k] = m_last[k];

      who_now = m_who[k];
      dv = 1'b0;
      if (!m_have[k]) begin
        dv = s_lv || s_sv;
        if (s_lv && s_sv) who_now = (rr && m_last[k] == 0) ? 1 : 0;
        else              who_now = s_lv ? 0 : 1;
      end else if (!m_acc[k]) begin
        dv = !(s_flush && m_who[k] == 0);
      end
      fire     = dv && s_ready;
      done_eff = m_have[k] && m_acc[k] && s_done;
      e_ld     = done_eff && m_who[k] == 0 && !m_sq[k] && !s_flush;
      e_sd     = done_eff && m_who[k] == 1;
      e_idx    = (who_now == 0) ? s_lidx : s_sidx;
      e_wd     = (who_now == 0) ? s_lwd  : s_swd;
      e_wm     = (who_now == 0) ? s_lwm  : s_swm;
      e_op     = (who_now == 0) ? s_lop  : s_sop;

      if (!reset_n) begin
        chk({p, "rst_valid"}, 64'(a_valid[k]), 64'(0));
        chk({p, "rst_index"}, a_idx[k], 64'(0));
        chk({p, "rst_wdata"}, a_wd[k], 64'(0));
        chk({p, "rst_wmask"}, a_wm[k], 64'(0));
        chk({p, "rst_optype"}, 64'(a_op[k]), 64'(0));
        chk({p, "rst_ldu_ready"}, 64'(a_lrdy[k]), 64'(0));
        chk({p, "rst_stu_ready"}, 64'(a_srdy[k]), 64'(0));
        chk({p, "rst_ldu_done"}, 64'(a_ldone[k]), 64'(0));
        chk({p, "rst_stu_done"}, 64'(a_sdone[k]), 64'(0));
        chk({p, "rst_ldu_rdata"}, a_lrd[k], 64'(0));
        chk({p, "rst_stu_rdata"}, a_srd[k], 64'(0));
        nh[k] = 1'b0; na[k] = 1'b0; ns[k] = 1'b0; nw[k] = 1; nl[k] = 1;
        if (k == 0) begin e_lrdy0 = 1'b0; e_srdy0 = 1'b0; end
      end else begin
        chk({p, "valid"}, 64'(a_valid[k]), 64'(dv));
        if (dv) begin
          chk({p, "index"}, a_idx[k], e_idx);
          chk({p, "wdata"}, a_wd[k], e_wd);
          chk({p, "wmask"}, a_wm[k], e_wm);
          chk({p, "optype"}, 64'(a_op[k]), 64'(e_op));
        end
        chk({p, "ldu_ready"}, 64'(a_lrdy[k]), 64'(fire && who_now == 0));
        chk({p, "stu_ready"}, 64'(a_srdy[k]), 64'(fire && who_now == 1));
        chk({p, "ldu_done"}, 64'(a_ldone[k]), 64'(e_ld));
        chk({p, "stu_done"}, 64'(a_sdone[k]), 64'(e_sd));
        chk({p, "ldu_rdata"}, a_lrd[k], s_rdata);
        chk({p, "stu_rdata"}, a_srd[k], s_rdata);
        if (k == 0) begin
          e_lrdy0 = fire && who_now == 0;
          e_srdy0 = fire && who_now == 1;
          if (e_ld || e_sd)
            $display("txn %s done rdata=0x%016h", e_ld ? "ldu" : "stu", s_rdata);
        end

        if (!m_have[k]) begin
          if (dv) begin
            nh[k] = 1'b1; nw[k] = who_now; na[k] = fire;
            if (fire) nl[k] = who_now;
          end
        end else if (!m_acc[k]) begin
          if (s_flush && m_who[k] == 0) nh[k] = 1'b0;
          else if (fire) begin na[k] = 1'b1; nl[k] = m_who[k]; end
        end else begin
          if (s_done) begin nh[k] = 1'b0; ns[k] = 1'b0; end
          else if (s_flush && m_who[k] == 0) ns[k] = 1'b1;
        end
      end

      sn_valid[k] = a_valid[k];
      sn_lrdy[k]  = a_lrdy[k];
      sn_srdy[k]  = a_srdy[k];
      sn_ldone[k] = a_ldone[k];
      sn_sdone[k] = a_sdone[k];
      sn_idx[k]   = a_idx[k];
      sn_lrd[k]   = a_lrd[k];
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      m_have[k] = nh[k]; m_acc[k] = na[k]; m_sq[k] = ns[k];
      m_who[k]  = nw[k]; m_last[k] = nl[k];
    end
    #1;
  endtask

  task automatic clear_inputs();
    s_lv = 1'b0; s_sv = 1'b0; s_ready = 1'b0; s_done = 1'b0; s_flush = 1'b0;
    s_lidx = 64'h0; s_lwd = 64'h0; s_lwm = 64'h0; s_lop = TBUS_READ;
    s_sidx = 64'h0; s_swd = 64'h0; s_swm = 64'h0; s_sop = TBUS_WRITE;
    s_rdata = 64'h0;
  endtask

  // Two reset cycles with busy inputs, then release with quiet inputs.
  task automatic do_reset();
    reset_n = 1'b0;
    s_lv = 1'b1; s_sv = 1'b1; s_ready = 1'b1; s_done = 1'b1;
    s_lidx = r64(); s_sidx = r64(); s_rdata = r64();
    step();
    step();
    reset_n = 1'b1;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int rst_left;
    bit exp_stu;
    model_reset();
    clear_inputs();
    e_lrdy0 = 1'b0;
    e_srdy0 = 1'b0;
    reset_n = 1'b0;
    #1;
    do_reset();
    for (int k = 0; k < 2; k++) chk("reset_valid", 64'(sn_valid[k]), 64'(0));

    // Load only: zero-latency grant, done three cycles after the fire
    s_lv = 1'b1; s_lidx = 64'h8000_1000; s_lop = TBUS_READ; s_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("ld_only_valid", 64'(sn_valid[k]), 64'(1));
      chk("ld_only_index", sn_idx[k], 64'h8000_1000);
      chk("ld_only_ready", 64'(sn_lrdy[k]), 64'(1));
    end
    s_lv = 1'b0; s_ready = 1'b0;
    step();
    step();
    s_done = 1'b1; s_rdata = 64'hDEAD_BEEF;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("ld_only_done", 64'(sn_ldone[k]), 64'(1));
      chk("ld_only_rdata", sn_lrd[k], 64'hDEAD_BEEF);
      chk("ld_only_stu_done", 64'(sn_sdone[k]), 64'(0));
    end
    s_done = 1'b0;

    // Tie: alternate on instance 0, load always on instance 1
    do_reset();
    s_lv = 1'b1; s_sv = 1'b1; s_lidx = 64'h1111; s_sidx = 64'h2222; s_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_done = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
        exp_stu = (k == 0) && (i % 2 == 1);
        chk("tie_ldu_grant", 64'(sn_lrdy[k]), 64'(!exp_stu));
        chk("tie_stu_grant", 64'(sn_srdy[k]), 64'(exp_stu));
      end
      s_done = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
        exp_stu = (k == 0) && (i % 2 == 1);
        chk("tie_ldu_done", 64'(sn_ldone[k]), 64'(!exp_stu));
        chk("tie_stu_done", 64'(sn_sdone[k]), 64'(exp_stu));
      end
    end
    clear_inputs();

    // Backpressure: store locked, load arrives in cycle 2, fire in cycle 5
    do_reset();
    s_sv = 1'b1; s_sidx = 64'h5000_0040; s_swd = 64'hA5A5; s_swm = 64'hFF;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin s_lv = 1'b1; s_lidx = 64'h9000_0000; end
      s_ready = (c == 5);
      step();
      for (int k = 0; k < 2; k++) begin
        chk("bp_index", sn_idx[k], 64'h5000_0040);
        chk("bp_ldu_ready", 64'(sn_lrdy[k]), 64'(0));
        chk("bp_stu_ready", 64'(sn_srdy[k]), 64'(c == 5));
      end
    end
    s_sv = 1'b0; s_ready = 1'b0; s_done = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("bp_stu_done", 64'(sn_sdone[k]), 64'(1));
    clear_inputs();

    // Flush while a load is locked; waiting store is granted next cycle
    do_reset();
    s_lv = 1'b1; s_lidx = 64'h7000_0000;
    step();
    s_sv = 1'b1; s_sidx = 64'h6000_0008;
    step();
    for (int k = 0; k < 2; k++) chk("fl_lock_index", sn_idx[k], 64'h7000_0000);
    s_flush = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("fl_lock_valid", 64'(sn_valid[k]), 64'(0));
    s_flush = 1'b0; s_lv = 1'b0; s_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("fl_lock_stu_valid", 64'(sn_valid[k]), 64'(1));
      chk("fl_lock_stu_index", sn_idx[k], 64'h6000_0008);
      chk("fl_lock_stu_ready", 64'(sn_srdy[k]), 64'(1));
    end
    s_sv = 1'b0; s_ready = 1'b0; s_done = 1'b1;
    step();
    clear_inputs();

    // Flush while a load is outstanding; its done is swallowed
    do_reset();
    s_lv = 1'b1; s_lidx = 64'h7100_0000; s_ready = 1'b1;
    step();
    s_lv = 1'b0; s_ready = 1'b0; s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    step();
    s_done = 1'b1; s_rdata = 64'h1234_5678;
    step();
    for (int k = 0; k < 2; k++) chk("fl_out_ldu_done", 64'(sn_ldone[k]), 64'(0));
    s_done = 1'b0; s_sv = 1'b1; s_sidx = 64'h6100_0000; s_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("fl_out_stu_ready", 64'(sn_srdy[k]), 64'(1));
    s_sv = 1'b0; s_ready = 1'b0; s_done = 1'b1;
    step();
    for (int k = 0; k < 2; k++) chk("fl_out_stu_done", 64'(sn_sdone[k]), 64'(1));
    clear_inputs();

    // Reset while outstanding, then a stray done
    do_reset();
    s_lv = 1'b1; s_lidx = 64'h7200_0000; s_ready = 1'b1;
    step();
    s_lv = 1'b0; s_ready = 1'b0;
    reset_n = 1'b0; s_done = 1'b1; s_sv = 1'b1; s_rdata = 64'hCAFE;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", 64'(sn_valid[k]), 64'(0));
      chk("rst_out_ldu_done", 64'(sn_ldone[k]), 64'(0));
      chk("rst_out_rdata", sn_lrd[k], 64'(0));
    end
    reset_n = 1'b1; s_sv = 1'b0; s_done = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("stray_ldu_done", 64'(sn_ldone[k]), 64'(0));
      chk("stray_stu_done", 64'(sn_sdone[k]), 64'(0));
    end
    clear_inputs();

    // Randomized run
    do_reset();
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        reset_n = 1'b0;
        rst_left = 2;
      end
      // Requesters hold until accepted; a redirect kills the load request.
      if (s_lv && (e_lrdy0 || s_flush)) s_lv = 1'b0;
      if (s_sv && e_srdy0) s_sv = 1'b0;
      if (!s_lv && $urandom_range(2) == 0) begin
        s_lv = 1'b1; s_lidx = r64(); s_lwd = r64(); s_lwm = r64();
        s_lop = 2'($urandom_range(1));
      end
      if (!s_sv && $urandom_range(2) == 0) begin
        s_sv = 1'b1; s_sidx = r64(); s_swd = r64(); s_swm = r64();
        s_sop = 2'($urandom_range(1));
      end
      s_ready = ($urandom_range(9) < 6);
      s_done  = ($urandom_range(9) < 3);
      s_flush = ($urandom_range(19) == 0);
      s_rdata = r64();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
